// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline latch for the pipelined MIPS datapath.
// Owns the PC, handles the imem ihit handshake, stalls, flushes, redirects and HALT parking.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        fetch_halted
);

    typedef enum logic [1:0] {
        StFetch     = 2'd0,
        StRedirPend = 2'd1,
        StHalted    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_npc_q, ifid_npc_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] pend_target;
    logic        bubble;

    assign pc_plus4    = pc_q + 32'd4;
    // Newest redirect wins over a target already parked in pend_pc.
    assign pend_target = redirect_valid ? redirect_pc : pend_pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_npc_d   = ifid_npc_q;
        ifid_valid_d = ifid_valid_q;
        bubble       = 1'b0;

        case (state_q)
            StFetch: begin
                if (redirect_valid) begin
                    bubble = 1'b1;
                    if (ihit) begin
                        pc_d = redirect_pc;
                    end else begin
                        // Outstanding access must complete before the PC may move.
                        pend_pc_d = redirect_pc;
                        state_d   = StRedirPend;
                    end
                end else if (flush) begin
                    bubble = 1'b1;
                    if (ihit) begin
                        pc_d = pc_plus4;
                    end
                end else if (stall) begin
                    // hold PC and IF/ID; any returned word is refetched later
                end else if (ihit) begin
                    ifid_instr_d = imemload;
                    ifid_npc_d   = pc_plus4;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                    if (imemload[31:26] == HALT_OP) begin
                        state_d = StHalted;
                    end
                end else begin
                    bubble = 1'b1;
                end
            end

            StRedirPend: begin
                pend_pc_d = pend_target;
                if (ihit) begin
                    pc_d    = pend_target;
                    state_d = StFetch;
                end
                if (redirect_valid || flush || !stall) begin
                    bubble = 1'b1;
                end
            end

            StHalted: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = StFetch;
                    bubble  = 1'b1;
                end else if (flush) begin
                    bubble = 1'b1;
                end
            end

            default: begin
                state_d = StFetch;
                bubble  = 1'b1;
            end
        endcase

        if (bubble) begin
            ifid_instr_d = 32'd0;
            ifid_npc_d   = 32'd0;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StFetch;
            pc_q         <= PC_INIT;
            pend_pc_q    <= PC_INIT;
            ifid_instr_q <= 32'd0;
            ifid_npc_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_npc_q   <= ifid_npc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imemaddr     = pc_q;
    assign imemREN      = !RST && (state_q != StHalted);
    assign fetch_halted = (state_q == StHalted);
    assign ifid_instr   = ifid_instr_q;
    assign ifid_npc     = ifid_npc_q;
    assign ifid_valid   = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: one vector per clock edge from reset,
// followed by hand-written sequences for PC wrap and reset during a pending redirect.
module tb_fetch_stage;

    localparam logic [31:0] W_A  = 32'h2001_0001;
    localparam logic [31:0] W_B  = 32'h2002_0002;
    localparam logic [31:0] W_C  = 32'h2003_0003;
    localparam logic [31:0] W_D  = 32'h2004_0004;
    localparam logic [31:0] W_E  = 32'h2005_0005;
    localparam logic [31:0] W_F  = 32'h2006_0006;
    localparam logic [31:0] W_G  = 32'h2007_0007;
    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam int NVEC = 22;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        fetch_halted;

    int tests = 0;
    int failed = 0;

    fetch_stage dut (
        .CLK            (CLK),
        .RST            (RST),
        .ihit           (ihit),
        .imemload       (imemload),
        .imemREN        (imemREN),
        .imemaddr       (imemaddr),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_instr     (ifid_instr),
        .ifid_npc       (ifid_npc),
        .ifid_valid     (ifid_valid),
        .fetch_halted   (fetch_halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ihit;
        logic [31:0] load;
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_ren;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        logic        e_valid;
        logic        e_halt;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic i, input logic [31:0] ld, input logic st,
                                input logic fl, input logic rv, input logic [31:0] rpc,
                                input logic [31:0] ea, input logic er, input logic [31:0] ei,
                                input logic [31:0] en, input logic ev, input logic eh);
        vec_t v;
        v.ihit = i;  v.load = ld; v.stall = st; v.flush = fl; v.rv = rv; v.rpc = rpc;
        v.e_addr = ea; v.e_ren = er; v.e_instr = ei; v.e_npc = en; v.e_valid = ev;
        v.e_halt = eh;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic i, input logic [31:0] ld, input logic st, input logic fl,
                         input logic rv, input logic [31:0] rpc);
        ihit = i; imemload = ld; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
    endtask

    task automatic check_all(input string tag, input int idx, input logic [31:0] ea,
                             input logic er, input logic [31:0] ei, input logic [31:0] en,
                             input logic ev, input logic eh);
        chk({tag, ".imemaddr"}, idx, imemaddr, ea);
        chk({tag, ".imemREN"}, idx, {31'd0, imemREN}, {31'd0, er});
        chk({tag, ".ifid_instr"}, idx, ifid_instr, ei);
        chk({tag, ".ifid_npc"}, idx, ifid_npc, en);
        chk({tag, ".ifid_valid"}, idx, {31'd0, ifid_valid}, {31'd0, ev});
        chk({tag, ".fetch_halted"}, idx, {31'd0, fetch_halted}, {31'd0, eh});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //            ihit load  st fl rv rpc        addr      ren instr npc       v  h
        // fetch A,B,C sequentially
        vecs[0]  = mk(1, W_A,  0, 0, 0, 0,         32'h04,   1, W_A,  32'h04,  1, 0);
        vecs[1]  = mk(1, W_B,  0, 0, 0, 0,         32'h08,   1, W_B,  32'h08,  1, 0);
        vecs[2]  = mk(1, W_C,  0, 0, 0, 0,         32'h0C,   1, W_C,  32'h0C,  1, 0);
        // stall 3 cycles with ihit, then resume with the same word
        vecs[3]  = mk(1, W_D,  1, 0, 0, 0,         32'h0C,   1, W_C,  32'h0C,  1, 0);
        vecs[4]  = mk(1, W_D,  1, 0, 0, 0,         32'h0C,   1, W_C,  32'h0C,  1, 0);
        vecs[5]  = mk(1, W_D,  1, 0, 0, 0,         32'h0C,   1, W_C,  32'h0C,  1, 0);
        vecs[6]  = mk(1, W_D,  0, 0, 0, 0,         32'h10,   1, W_D,  32'h10,  1, 0);
        // redirect to 0x40 without ihit: address held until the access completes
        vecs[7]  = mk(0, W_E,  0, 0, 1, 32'h40,    32'h10,   1, 0,    0,       0, 0);
        vecs[8]  = mk(1, W_E,  0, 0, 0, 0,         32'h40,   1, 0,    0,       0, 0);
        vecs[9]  = mk(0, W_F,  0, 0, 0, 0,         32'h40,   1, 0,    0,       0, 0);
        vecs[10] = mk(1, W_F,  0, 0, 0, 0,         32'h44,   1, W_F,  32'h44,  1, 0);
        // redirect + stall + ihit on the same edge
        vecs[11] = mk(1, W_G,  1, 0, 1, 32'h10,    32'h10,   1, 0,    0,       0, 0);
        // HALT at 0x10, park, flush, then redirect out to 0x20
        vecs[12] = mk(1, HALT, 0, 0, 0, 0,         32'h14,   0, HALT, 32'h14,  1, 1);
        vecs[13] = mk(0, 0,    0, 0, 0, 0,         32'h14,   0, HALT, 32'h14,  1, 1);
        vecs[14] = mk(0, 0,    0, 1, 0, 0,         32'h14,   0, 0,    0,       0, 1);
        vecs[15] = mk(0, 0,    0, 0, 1, 32'h20,    32'h20,   1, 0,    0,       0, 0);
        // flush with ihit drops the word but advances pc
        vecs[16] = mk(1, W_A,  0, 1, 0, 0,         32'h24,   1, 0,    0,       0, 0);
        vecs[17] = mk(1, W_B,  0, 0, 0, 0,         32'h28,   1, W_B,  32'h28,  1, 0);
        // two redirects while pending: newest target wins
        vecs[18] = mk(0, 0,    0, 0, 1, 32'h80,    32'h28,   1, 0,    0,       0, 0);
        vecs[19] = mk(0, 0,    0, 0, 1, 32'h90,    32'h28,   1, 0,    0,       0, 0);
        vecs[20] = mk(1, W_D,  0, 0, 0, 0,         32'h90,   1, 0,    0,       0, 0);
        vecs[21] = mk(1, W_C,  0, 0, 0, 0,         32'h94,   1, W_C,  32'h94,  1, 0);

        RST = 1'b1;
        drive(1, W_A, 0, 0, 0, 0);
        tick();
        tick();
        check_all("reset", 0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        RST = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ihit, vecs[i].load, vecs[i].stall, vecs[i].flush, vecs[i].rv,
                  vecs[i].rpc);
            tick();
            check_all("vec", i, vecs[i].e_addr, vecs[i].e_ren, vecs[i].e_instr,
                      vecs[i].e_npc, vecs[i].e_valid, vecs[i].e_halt);
        end

        // PC wrap: jump to 0xFFFFFFFC, fetch there -> npc and pc wrap to 0
        drive(1, W_G, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        check_all("wrap_redir", 0, 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1, W_A, 0, 0, 0, 0);
        tick();
        check_all("wrap", 0, 32'h0, 1'b1, W_A, 32'h0, 1'b1, 1'b0);

        // Reset while a redirect is pending abandons it
        drive(1, W_A, 0, 0, 0, 0);
        tick();
        check_all("pend_setup", 0, 32'h4, 1'b1, W_A, 32'h4, 1'b1, 1'b0);
        drive(0, 0, 0, 0, 1, 32'h200);
        tick();
        check_all("pend", 0, 32'h4, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        RST = 1'b1;
        drive(1, W_B, 0, 0, 0, 0);
        tick();
        check_all("pend_rst", 0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check_all("post_rst", 0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1, W_B, 0, 0, 0, 0);
        tick();
        check_all("post_rst", 1, 32'h4, 1'b1, W_B, 32'h4, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
